// File: rtl/pg_sequencer_pkg.sv
// Shared types for the power-gating sequencer: state encoding, counter width,
// and the per-state drive of the domain-boundary controls (clamp, switch, reset).
// Used by the sequencer, its delay counter, isolation-cell sites and debug logic.
package pg_sequencer_pkg;

    localparam int PG_CNT_W   = 8;
    localparam int PG_STATE_W = 3;

    typedef logic [PG_CNT_W-1:0] pg_cnt_t;

    typedef enum logic [PG_STATE_W-1:0] {
        ST_OFF       = 3'd0,
        ST_PWR_UP    = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_ON        = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_ISO_SETUP = 3'd5
    } pg_state_e;

    typedef struct packed {
        logic clamp_en;
        logic sleep_en;
        logic domain_rst;
    } pg_ctrl_t;

    // Boundary controls per state; anything unknown is treated as OFF (safe side).
    function automatic pg_ctrl_t pg_decode(pg_state_e s);
        pg_ctrl_t c;
        case (s)
            ST_PWR_UP:    c = '{clamp_en: 1'b1, sleep_en: 1'b0, domain_rst: 1'b1};
            ST_RST_HOLD:  c = '{clamp_en: 1'b1, sleep_en: 1'b0, domain_rst: 1'b1};
            ST_ON:        c = '{clamp_en: 1'b0, sleep_en: 1'b0, domain_rst: 1'b0};
            ST_WAIT_IDLE: c = '{clamp_en: 1'b0, sleep_en: 1'b0, domain_rst: 1'b0};
            ST_ISO_SETUP: c = '{clamp_en: 1'b1, sleep_en: 1'b0, domain_rst: 1'b0};
            default:      c = '{clamp_en: 1'b1, sleep_en: 1'b1, domain_rst: 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pg_sequencer_if.sv
// Request/control bundle between a power manager and the power-gating sequencer.
// Pure wiring, no latency; level-based request, no backpressure.
// master = power manager / bench side, slave = sequencer side.
interface pg_sequencer_if
    import pg_sequencer_pkg::*;
();
    logic                  pgReq;
    logic                  domainIdle;
    logic                  clampEn;
    logic                  sleepEn;
    logic                  domainRst;
    logic                  isOn;
    logic                  isOff;
    logic [PG_STATE_W-1:0] pgState;

    modport master (
        output pgReq, domainIdle,
        input  clampEn, sleepEn, domainRst, isOn, isOff, pgState
    );

    modport slave (
        input  pgReq, domainIdle,
        output clampEn, sleepEn, domainRst, isOn, isOff, pgState
    );
endinterface

// File: rtl/pg_delay_counter.sv
// Shared down-counter timing the PWR_UP, RST_HOLD and ISO_SETUP states.
// done is registered-state decode (counter at zero); load takes effect next edge.
// Saturates at zero so an unloaded counter never wraps; no backpressure.
module pg_delay_counter
    import pg_sequencer_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  pg_cnt_t loadVal,
    output logic    done
);

    pg_cnt_t cnt_q;
    pg_cnt_t cnt_d;

    // Load on state entry, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = loadVal;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - pg_cnt_t'(1);
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/pg_sequencer.sv
// Power-gating sequencer: clamp -> switch off on power-down, switch on -> reset release -> unclamp on power-up.
// Moore FSM, all outputs registered alongside the state; timed states last exactly their parameter in cycles.
// pgReq is a level and is ignored inside the timed states (non-abortable); no backpressure.
module pg_sequencer
    import pg_sequencer_pkg::*;
#(
    parameter int PWR_UP_CYCLES    = 8,
    parameter int RST_CYCLES       = 4,
    parameter int ISO_SETUP_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    pg_sequencer_if.slave  pg
);

    // Counter reload values: the state exits on the edge where the counter reads zero.
    localparam pg_cnt_t PWR_UP_LOAD = pg_cnt_t'(PWR_UP_CYCLES - 1);
    localparam pg_cnt_t RST_LOAD    = pg_cnt_t'(RST_CYCLES - 1);
    localparam pg_cnt_t ISO_LOAD    = pg_cnt_t'(ISO_SETUP_CYCLES - 1);

    pg_state_e state_q;
    pg_state_e state_d;
    pg_ctrl_t  ctrl_q;
    logic      is_on_q;
    logic      is_off_q;

    logic      cnt_load;
    pg_cnt_t   cnt_val;
    logic      cnt_done;

    pg_delay_counter u_delay (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .loadVal (cnt_val),
        .done    (cnt_done)
    );

    // Next-state selection and counter load on entry to each timed state.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_OFF: begin
                if (!pg.pgReq) begin
                    state_d  = ST_PWR_UP;
                    cnt_load = 1'b1;
                    cnt_val  = PWR_UP_LOAD;
                end
            end
            ST_PWR_UP: begin
                if (cnt_done) begin
                    state_d  = ST_RST_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = RST_LOAD;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_done) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (pg.pgReq) begin
                    if (pg.domainIdle) begin
                        state_d  = ST_ISO_SETUP;
                        cnt_load = 1'b1;
                        cnt_val  = ISO_LOAD;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A dropped request aborts the power-down before any clamping happens.
                if (!pg.pgReq) begin
                    state_d = ST_ON;
                end else if (pg.domainIdle) begin
                    state_d  = ST_ISO_SETUP;
                    cnt_load = 1'b1;
                    cnt_val  = ISO_LOAD;
                end
            end
            ST_ISO_SETUP: begin
                if (cnt_done) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // State plus registered decode of the boundary controls; reset lands directly in OFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_OFF;
            ctrl_q   <= pg_decode(ST_OFF);
            is_on_q  <= 1'b0;
            is_off_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= pg_decode(state_d);
            is_on_q  <= (state_d == ST_ON);
            is_off_q <= (state_d == ST_OFF);
        end
    end

    assign pg.clampEn   = ctrl_q.clamp_en;
    assign pg.sleepEn   = ctrl_q.sleep_en;
    assign pg.domainRst = ctrl_q.domain_rst;
    assign pg.isOn      = is_on_q;
    assign pg.isOff     = is_off_q;
    assign pg.pgState   = state_q;

endmodule
